// File: rtl/vadd_job_scheduler.sv
// -----------------------------------------------------------------------------
// vadd_job_scheduler
//
// Job sequencer in front of the vadd datapath. Host logic pushes job
// descriptors (address offset, byte size, adder constant) into a small FIFO.
// The scheduler issues them to the datapath one at a time:
//   1. pop a descriptor,
//   2. present its config on dp_*,
//   3. pulse dp_ap_start,
//   4. wait for dp_ap_done.
// Every finished job produces a one-cycle done pulse, and a running count of
// completed jobs is kept.
//
// Optional feature macro: VADD_SCHED_TIMEOUT_EN
//   When defined, a watchdog bounds the wait for dp_ap_done to
//   C_TIMEOUT_CYCLES cycles. An expired job completes with an error and sets
//   the sticky timeout_flag. While the flag is set, no new descriptors are
//   accepted. When undefined, the wait is unbounded and timeout_flag is 0.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_job_valid/ready   descriptor handshake (accepted when both are high)
//   s_job_addr/size/constant  descriptor payload
//   s_job_id            id that the descriptor offered this cycle will receive
//   dp_ap_start         one-cycle start pulse to the datapath
//   dp_ap_done          datapath completion pulse
//   dp_addr_offset, dp_xfer_size, dp_constant  config held for the datapath
//   done_valid/id/error per-job completion pulse, id and error flag
//   busy                a job is in progress or descriptors are queued
//   jobs_completed      number of done pulses since reset (wraps)
//   timeout_flag        sticky watchdog flag
// -----------------------------------------------------------------------------
module vadd_job_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_JOB_FIFO_DEPTH   = 4,
  parameter int C_TIMEOUT_CYCLES   = 1048576
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_job_valid,
  output logic                          s_job_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s_job_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  s_job_size,
  input  logic [C_ADDER_BIT_WIDTH-1:0]  s_job_constant,
  output logic [7:0]                    s_job_id,
  output logic                          dp_ap_start,
  input  logic                          dp_ap_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dp_xfer_size,
  output logic [C_ADDER_BIT_WIDTH-1:0]  dp_constant,
  output logic                          done_valid,
  output logic [7:0]                    done_id,
  output logic                          done_error,
  output logic                          busy,
  output logic [31:0]                   jobs_completed,
  output logic                          timeout_flag
);

  localparam int IDX_W = $clog2(C_JOB_FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_mem  [C_JOB_FIFO_DEPTH];
  logic [C_XFER_SIZE_WIDTH-1:0]  size_mem  [C_JOB_FIFO_DEPTH];
  logic [C_ADDER_BIT_WIDTH-1:0]  const_mem [C_JOB_FIFO_DEPTH];
  logic [7:0]                    id_mem    [C_JOB_FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [2:0]       state;
  logic [IDX_W-1:0] load_idx;
  logic [7:0]       next_id;
  logic [7:0]       cur_id;
  logic             cur_err;
  logic [31:0]      done_count;

`ifdef VADD_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(C_TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout_q;
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // Ready is masked during reset so that every output reads 0 while
  // areset is held. Readiness depends only on the pre-pop fill level, so a
  // full FIFO refuses a push even in a cycle where it pops.
  assign s_job_ready = !full && !timeout_flag && !areset;
  assign push        = s_job_valid && s_job_ready;
  assign pop         = (state == ST_IDLE) && !empty;

  assign s_job_id       = next_id;
  assign dp_ap_start    = (state == ST_START);
  assign done_valid     = (state == ST_DONE);
  assign done_id        = cur_id;
  assign done_error     = cur_err;
  assign busy           = (state != ST_IDLE) || !empty;
  assign jobs_completed = done_count;

  // Descriptor storage. The id travels with the descriptor.
  always_ff @(posedge aclk) begin
    if (push) begin
      addr_mem[wr_ptr[IDX_W-1:0]]  <= s_job_addr;
      size_mem[wr_ptr[IDX_W-1:0]]  <= s_job_size;
      const_mem[wr_ptr[IDX_W-1:0]] <= s_job_constant;
      id_mem[wr_ptr[IDX_W-1:0]]    <= next_id;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      next_id <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        next_id <= next_id + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // The popped slot index is remembered so LOAD can read the entry one cycle
  // later. A push landing in that freed slot on the LOAD edge is harmless,
  // because LOAD samples the old contents.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= ST_IDLE;
      load_idx       <= '0;
      dp_addr_offset <= '0;
      dp_xfer_size   <= '0;
      dp_constant    <= '0;
      cur_id         <= 8'd0;
      cur_err        <= 1'b0;
      done_count     <= 32'd0;
`ifdef VADD_SCHED_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            load_idx <= rd_ptr[IDX_W-1:0];
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          dp_addr_offset <= addr_mem[load_idx];
          dp_xfer_size   <= size_mem[load_idx];
          dp_constant    <= const_mem[load_idx];
          cur_id         <= id_mem[load_idx];
          if (size_mem[load_idx] == '0) begin
            cur_err    <= 1'b1;
            done_count <= done_count + 32'd1;
            state      <= ST_DONE;
          end else begin
            cur_err <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          // A done arriving in this cycle is deliberately ignored.
`ifdef VADD_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dp_ap_done) begin
            done_count <= done_count + 32'd1;
            state      <= ST_DONE;
`ifdef VADD_SCHED_TIMEOUT_EN
          end else if (wait_cnt == TO_W'(C_TIMEOUT_CYCLES - 1)) begin
            cur_err    <= 1'b1;
            timeout_q  <= 1'b1;
            done_count <= done_count + 32'd1;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vadd_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vadd_job_scheduler
//
// Testbench for vadd_job_scheduler. It runs directed scenarios with literal
// expectations, then a randomized phase. A transaction-level model, built
// from a descriptor queue and job timestamps, predicts every output on every
// cycle. Build it with VADD_SCHED_TIMEOUT_EN to also cover the watchdog,
// with C_TIMEOUT_CYCLES set to 16.
// -----------------------------------------------------------------------------
module tb_vadd_job_scheduler;

  localparam int DEPTH = 4;
`ifdef VADD_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic        aclk;
  logic        areset;
  logic        s_job_valid;
  logic        s_job_ready;
  logic [63:0] s_job_addr;
  logic [31:0] s_job_size;
  logic [31:0] s_job_constant;
  logic [7:0]  s_job_id;
  logic        dp_ap_start;
  logic        dp_ap_done;
  logic [63:0] dp_addr_offset;
  logic [31:0] dp_xfer_size;
  logic [31:0] dp_constant;
  logic        done_valid;
  logic [7:0]  done_id;
  logic        done_error;
  logic        busy;
  logic [31:0] jobs_completed;
  logic        timeout_flag;

  vadd_job_scheduler #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_XFER_SIZE_WIDTH (32),
    .C_ADDER_BIT_WIDTH (32),
`ifdef VADD_SCHED_TIMEOUT_EN
    .C_TIMEOUT_CYCLES  (TO),
`endif
    .C_JOB_FIFO_DEPTH  (DEPTH)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_job_valid   (s_job_valid),
    .s_job_ready   (s_job_ready),
    .s_job_addr    (s_job_addr),
    .s_job_size    (s_job_size),
    .s_job_constant(s_job_constant),
    .s_job_id      (s_job_id),
    .dp_ap_start   (dp_ap_start),
    .dp_ap_done    (dp_ap_done),
    .dp_addr_offset(dp_addr_offset),
    .dp_xfer_size  (dp_xfer_size),
    .dp_constant   (dp_constant),
    .done_valid    (done_valid),
    .done_id       (done_id),
    .done_error    (done_error),
    .busy          (busy),
    .jobs_completed(jobs_completed),
    .timeout_flag  (timeout_flag)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Jobs are tracked by the edge at which they were popped.
  // From that pop edge p:
  //   - config appears at p+1, together with start (or done, for size 0),
  //   - done is accepted from p+3 onward,
  //   - the next pop can happen no earlier than 2 edges after a done.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] addr;
    logic [31:0] size;
    logic [31:0] cst;
    logic [7:0]  id;
  } job_t;

  job_t        q[$];
  job_t        cur;
  int          edge_n = 0;
  bit          model_on = 1'b0;
  bit          in_flight;
  int          pop_e;
  int          free_at;
  int          last_done_e;
  int          m_next_id;
  logic [31:0] m_count;
  bit          m_flag;
  bit          e_start;
  bit          e_done;
  bit          e_err;
  logic [7:0]  e_done_id;
  logic [63:0] e_addr;
  logic [31:0] e_size;
  logic [31:0] e_cst;

  task automatic modelFinish(input bit err);
    in_flight   = 1'b0;
    e_done      = 1'b1;
    e_err       = err;
    e_done_id   = cur.id;
    m_count     = m_count + 32'd1;
    free_at     = edge_n + 2;
    last_done_e = edge_n;
  endtask

  always @(posedge aclk) begin : model
    bit   rdy;
    job_t j;
    edge_n++;
    e_start = 1'b0;
    e_done  = 1'b0;
    if (areset) begin
      q.delete();
      in_flight   = 1'b0;
      free_at     = edge_n + 1;
      last_done_e = -10;
      m_next_id   = 0;
      m_count     = 32'd0;
      m_flag      = 1'b0;
      e_err       = 1'b0;
      e_done_id   = 8'd0;
      e_addr      = 64'd0;
      e_size      = 32'd0;
      e_cst       = 32'd0;
      model_on    = 1'b1;
    end else if (model_on) begin
      rdy = (q.size() < DEPTH) && !m_flag;
      if (!in_flight && edge_n >= free_at && q.size() > 0) begin
        cur       = q.pop_front();
        in_flight = 1'b1;
        pop_e     = edge_n;
      end else if (in_flight) begin
        if (edge_n == pop_e + 1) begin
          e_addr = cur.addr;
          e_size = cur.size;
          e_cst  = cur.cst;
          if (cur.size == 32'd0) modelFinish(1'b1);
          else e_start = 1'b1;
        end else if (edge_n >= pop_e + 3) begin
          if (dp_ap_done) modelFinish(1'b0);
`ifdef VADD_SCHED_TIMEOUT_EN
          else if (edge_n == pop_e + 2 + TO) begin
            modelFinish(1'b1);
            m_flag = 1'b1;
          end
`endif
        end
      end
      if (s_job_valid && rdy) begin
        j.addr = s_job_addr;
        j.size = s_job_size;
        j.cst  = s_job_constant;
        j.id   = m_next_id[7:0];
        q.push_back(j);
        m_next_id = (m_next_id + 1) % 256;
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge aclk) begin
    if (model_on) begin
      checkOutput("ready", s_job_ready, (q.size() < DEPTH) && !m_flag && !areset);
      checkOutput("job_id", s_job_id, m_next_id[7:0]);
      checkOutput("dp_start", dp_ap_start, e_start);
      checkOutput("done_valid", done_valid, e_done);
      if (e_done) begin
        checkOutput("done_id", done_id, e_done_id);
        checkOutput("done_error", done_error, e_err);
      end
      checkOutput("busy", busy, in_flight || (last_done_e == edge_n) || (q.size() > 0));
      checkOutput("jobs_completed", jobs_completed, m_count);
      checkOutput("timeout_flag", timeout_flag, m_flag);
      checkOutput("dp_addr", dp_addr_offset, e_addr);
      checkOutput("dp_size", dp_xfer_size, e_size);
      checkOutput("dp_const", dp_constant, e_cst);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] a,
                               input logic [31:0] s, input logic [31:0] c,
                               input logic d);
    s_job_valid    = v;
    s_job_addr     = a;
    s_job_size     = s;
    s_job_constant = c;
    dp_ap_done     = d;
  endtask

  task automatic doReset();
    areset = 1'b1;
    tick();
    checkOutput("rst_ready", s_job_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", jobs_completed, 0);
    checkOutput("rst_done", done_valid, 0);
    checkOutput("rst_start", dp_ap_start, 0);
    checkOutput("rst_dp_addr", dp_addr_offset, 0);
    checkOutput("rst_id", s_job_id, 0);
    areset = 1'b0;
    #1;
    checkOutput("rst_ready_release", s_job_ready, 1);
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int n;
    int waits;
    areset = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
    tick();

    // 1: single job, start two edges after push, done 20 cycles after start
    doReset();
    applyStimulus(1'b1, 64'h1000, 32'd4096, 32'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("t1_no_start_early", dp_ap_start, 0);
    tick();
    checkOutput("t1_start", dp_ap_start, 1);
    checkOutput("t1_dp_addr", dp_addr_offset, 64'h1000);
    checkOutput("t1_dp_size", dp_xfer_size, 4096);
    checkOutput("t1_dp_const", dp_constant, 5);
    repeat (19) tick();
    dp_ap_done = 1'b1;
    tick();
    dp_ap_done = 1'b0;
    checkOutput("t1_done_valid", done_valid, 1);
    checkOutput("t1_done_id", done_id, 0);
    checkOutput("t1_done_err", done_error, 0);
    checkOutput("t1_count", jobs_completed, 1);
    checkOutput("t1_dp_hold", dp_addr_offset, 64'h1000);
    tick();
    checkOutput("t1_done_pulse", done_valid, 0);

    // 2: back-to-back pushes without done; the FIFO fills and a push stalls
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 64'h2000 + 64'(k) * 64'h100, 32'd64, 32'(k + 1), 1'b0);
      if (k == 5) begin
        checkOutput("t2_stall", s_job_ready, 0);
        dp_ap_done = 1'b1;
        tick();
        dp_ap_done = 1'b0;
      end
      waits = 0;
      while (!s_job_ready && waits < 50) begin
        tick();
        waits++;
      end
      if (waits >= 50) checkOutput("t2_ready_timeout", waits, 0);
      checkOutput("t2_id", s_job_id, k);
      tick();
    end
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);

    // 3: zero-size job completes with error and no start pulse
    doReset();
    applyStimulus(1'b1, 64'h3000, 32'd0, 32'd9, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("t3_no_done_yet", done_valid, 0);
    tick();
    checkOutput("t3_done_valid", done_valid, 1);
    checkOutput("t3_done_err", done_error, 1);
    checkOutput("t3_start", dp_ap_start, 0);
    checkOutput("t3_count", jobs_completed, 1);

    // 4: spurious done in IDLE and START is ignored
    dp_ap_done = 1'b1;
    repeat (3) tick();
    checkOutput("t4_idle_ignored", jobs_completed, 1);
    applyStimulus(1'b1, 64'h4000, 32'd128, 32'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b1);
    tick();
    tick();
    checkOutput("t4_start", dp_ap_start, 1);
    tick();
    dp_ap_done = 1'b0;
    checkOutput("t4_start_done_ignored", done_valid, 0);
    tick();
    tick();
    checkOutput("t4_still_waiting", done_valid, 0);
    dp_ap_done = 1'b1;
    tick();
    dp_ap_done = 1'b0;
    checkOutput("t4_done_valid", done_valid, 1);
    checkOutput("t4_done_err", done_error, 0);
    checkOutput("t4_count", jobs_completed, 2);

    // 5: reset while waiting with two queued jobs
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 64'h5000 + 64'(k), 32'd16, 32'd1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("t5_busy_before", busy, 1);
    doReset();
    repeat (4) begin
      tick();
      checkOutput("t5_no_done", done_valid, 0);
      checkOutput("t5_idle", busy, 0);
    end
    checkOutput("t5_id_restart", s_job_id, 0);

`ifdef VADD_SCHED_TIMEOUT_EN
    // 6: watchdog expiry after TO cycles in WAIT
    applyStimulus(1'b1, 64'h6000, 32'd16, 32'd3, 1'b0);
    tick();
    n = edge_n;
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
    waits = 0;
    while (!done_valid && waits < 60) begin
      tick();
      waits++;
    end
    checkOutput("t6_timeout_edge", edge_n - n, 19);
    checkOutput("t6_done_err", done_error, 1);
    checkOutput("t6_flag", timeout_flag, 1);
    checkOutput("t6_ready", s_job_ready, 0);
    applyStimulus(1'b1, 64'h6100, 32'd16, 32'd3, 1'b0);
    repeat (3) tick();
    checkOutput("t6_push_refused", s_job_id, 1);
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
`else
    n = 0;
`endif

    // Randomized phase
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom,
                    ($urandom_range(0, 5) == 0));
      areset = ($urandom_range(0, 399) == 0);
      tick();
    end
    areset = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
